led_blade_seq: RTL and testbench

Parametrised LED blade sequencer, the successor to the fixed 6-bit binary-count blade driver. A prescaler divides `clk` down to a step tick. On each tick a WIDTH-bit pattern register advances in one of four runtime-selectable modes: count up, count down, rotate, or bounce. The block also supports parallel load, a heartbeat LED and selectable output polarity. It sits directly on the board LED pins in the synthesis top-levels.

---
 rtl/led_blade_seq.sv | 142 ++++++++++++++
 tb/tb_led_blade_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blade_seq.sv
// led_blade_seq: prescaled LED blade sequencer.
// A prescaler turns clk into a step tick every DIVIDE cycles; on each tick
// the WIDTH-bit pattern advances as an up-counter, down-counter, one-hot
// rotator or one-hot bouncing sweep, selected at runtime by mode.
//
// Ports:
//   clk        - single clock, rising edge
//   reset_n    - synchronous active-low reset
//   enable     - 1 runs prescaler/stepping, 0 freezes the pattern
//   mode       - 00 up, 01 down, 10 rotate-left one-hot, 11 bounce one-hot
//   load       - single-cycle parallel load strobe (beats stepping)
//   load_value - value written to the pattern on load
//   tick       - registered pulse, high the cycle a new pattern appears
//   led        - heartbeat, toggles on every tick
//   blade      - pattern after output polarity (inverted when ACTIVE_LOW)
//
// Bounce direction state:
//   dir | meaning
//   ----+-------------------------------
//    0  | sweeping toward MSB (shift left)
//    1  | sweeping toward LSB (shift right)
module led_blade_seq #(
   parameter int WIDTH      = 6,
   parameter int DIVIDE     = 16777216,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             tick,
   output logic             led,
   output logic [WIDTH-1:0] blade
);

   localparam int CW = $clog2(DIVIDE);
   // Prescaler is a down-counter: it reloads to DIVIDE-1 and a step fires
   // when it reaches zero, so the first tick lands on the DIVIDE-th edge.
   localparam logic [CW-1:0] TC_LOAD = CW'(DIVIDE - 1);

   logic [CW-1:0]    cnt,     cnt_nxt;
   logic [WIDTH-1:0] pattern, pat_nxt;
   logic             dir,     dir_nxt;
   logic             tick_q,  tick_nxt;
   logic             led_q,   led_nxt;

   logic [WIDTH-1:0] step_pat;
   logic             step_dir;
   logic             onehot;

   // State register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt     <= TC_LOAD;
         pattern <= '0;
         dir     <= 1'b0;
         tick_q  <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         pattern <= pat_nxt;
         dir     <= dir_nxt;
         tick_q  <= tick_nxt;
         led_q   <= led_nxt;
      end
   end

   assign onehot = (pattern != '0) && ((pattern & (pattern - WIDTH'(1))) == '0);

   // Pattern that a tick would produce in the current mode
   always_comb begin
      step_pat = pattern;
      step_dir = dir;
      unique case (mode)
         2'b00: step_pat = pattern + WIDTH'(1);
         2'b01: step_pat = pattern - WIDTH'(1);
         2'b10: begin
            if (!onehot) step_pat = WIDTH'(1);
            else         step_pat = {pattern[WIDTH-2:0], pattern[WIDTH-1]};
         end
         default: begin
            if (!onehot) begin
               step_pat = WIDTH'(1);
               step_dir = 1'b0;
            end else if (!dir) begin
               // A pattern parked on the MSB with dir=0 (e.g. just loaded)
               // turns around instead of shifting out to zero.
               if (pattern[WIDTH-1]) begin
                  step_pat = pattern >> 1;
                  step_dir = 1'b1;
               end else begin
                  step_pat = pattern << 1;
                  step_dir = step_pat[WIDTH-1];
               end
            end else begin
               if (pattern[0]) begin
                  step_pat = pattern << 1;
                  step_dir = 1'b0;
               end else begin
                  step_pat = pattern >> 1;
                  step_dir = !step_pat[0];
               end
            end
         end
      endcase
   end

   // Next-state logic: load > enable-low > step
   always_comb begin
      cnt_nxt  = cnt;
      pat_nxt  = pattern;
      dir_nxt  = dir;
      tick_nxt = 1'b0;
      led_nxt  = led_q;
      if (load) begin
         pat_nxt = load_value;
         cnt_nxt = TC_LOAD;
         dir_nxt = 1'b0;
      end else if (!enable) begin
         cnt_nxt = TC_LOAD;
      end else if (cnt == '0) begin
         cnt_nxt  = TC_LOAD;
         tick_nxt = 1'b1;
         led_nxt  = !led_q;
         pat_nxt  = step_pat;
         dir_nxt  = step_dir;
      end else begin
         cnt_nxt = cnt - CW'(1);
      end
      if (mode != 2'b11) dir_nxt = 1'b0;
   end

   // Outputs straight from flops
   always_comb begin
      tick  = tick_q;
      led   = led_q;
      blade = ACTIVE_LOW ? ~pattern : pattern;
   end

endmodule

// File: tb/tb_led_blade_seq.sv
// Testbench for led_blade_seq with WIDTH=6, DIVIDE=4, ACTIVE_LOW=1.
// Directed scenarios plus a randomized run checked against a cycle-level
// behavioural model that tracks elapsed prescale cycles and the pattern
// as plain integers.
module tb_led_blade_seq;

   localparam int W   = 6;
   localparam int DIV = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         enable;
   logic [1:0]   mode;
   logic         load;
   logic [W-1:0] load_value;
   logic         tick;
   logic         led;
   logic [W-1:0] blade;

   int checks = 0;
   int errors = 0;

   // model state
   int m_cnt, m_pat, m_dir, m_tick, m_led;

   led_blade_seq #(.WIDTH(W), .DIVIDE(DIV), .ACTIVE_LOW(1'b1)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable     (enable),
      .mode       (mode),
      .load       (load),
      .load_value (load_value),
      .tick       (tick),
      .led        (led),
      .blade      (blade)
   );

   always #5 clk = ~clk;

   task automatic model_next(input int md);
      int p;
      p = m_pat;
      case (md)
         0: m_pat = (p + 1) % 64;
         1: m_pat = (p + 63) % 64;
         2: m_pat = ($countones(p) != 1) ? 1 : ((p == 32) ? 1 : p * 2);
         default: begin
            if ($countones(p) != 1) begin
               m_pat = 1; m_dir = 0;
            end else if (m_dir == 0) begin
               if (p == 32) begin m_pat = 16; m_dir = 1; end
               else begin m_pat = p * 2; if (m_pat == 32) m_dir = 1; end
            end else begin
               if (p == 1) begin m_pat = 2; m_dir = 0; end
               else begin m_pat = p / 2; if (m_pat == 1) m_dir = 0; end
            end
         end
      endcase
   endtask

   task automatic model_edge();
      if (!reset_n) begin
         m_cnt = 0; m_pat = 0; m_dir = 0; m_tick = 0; m_led = 0;
      end else if (load) begin
         m_pat = int'(load_value); m_cnt = 0; m_dir = 0; m_tick = 0;
      end else if (!enable) begin
         m_cnt = 0; m_tick = 0;
      end else if (m_cnt == DIV - 1) begin
         m_cnt = 0; m_tick = 1; m_led = 1 - m_led;
         model_next(int'(mode));
      end else begin
         m_cnt = m_cnt + 1; m_tick = 0;
      end
      if (reset_n && mode != 2'b11) m_dir = 0;
   endtask

   task automatic clk_cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) clk_cycle();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b0; mode = 2'b00; load = 1'b0; load_value = '0;
      run(3);
      checks++;
      if (blade !== 6'b111111) begin errors++; $display("FAIL reset_blade got %b want %b", blade, 6'b111111); end
      checks++;
      if (led !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL reset_led_tick got led=%b tick=%b want 0 0", led, tick); end
      reset_n = 1'b1; enable = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         clk_cycle();
         checks++;
         if (tick !== 1'b0) begin errors++; $display("FAIL reset_early_tick edge %0d got %b want 0", i, tick); end
      end
      clk_cycle();
      checks++;
      if (tick !== 1'b1 || blade !== 6'b111110 || led !== 1'b1) begin
         errors++;
         $display("FAIL reset_first_tick got tick=%b blade=%b led=%b want 1 111110 1", tick, blade, led);
      end
   endtask

   task automatic test_upcount_wrap();
      mode = 2'b00; load = 1'b1; load_value = 6'h3F;
      clk_cycle();
      load = 1'b0;
      checks++;
      if (blade !== 6'h00) begin errors++; $display("FAIL load_latency got %h want 00", blade); end
      run(DIV);
      checks++;
      if (blade !== 6'h3F || tick !== 1'b1) begin errors++; $display("FAIL up_wrap got blade=%h tick=%b want 3f 1", blade, tick); end
      mode = 2'b01;
      run(DIV);
      checks++;
      if (blade !== 6'h00) begin errors++; $display("FAIL down_wrap got blade=%h want 00", blade); end
   endtask

   task automatic test_rotate();
      int exp_seq[7] = '{1, 2, 4, 8, 16, 32, 1};
      reset_n = 1'b0; mode = 2'b10; enable = 1'b1;
      clk_cycle();
      reset_n = 1'b1;
      foreach (exp_seq[i]) begin
         run(DIV);
         checks++;
         if (blade !== ~W'(exp_seq[i])) begin
            errors++; $display("FAIL rotate_step%0d got blade=%b want %b", i, blade, ~W'(exp_seq[i]));
         end
      end
      load = 1'b1; load_value = 6'b000101;
      clk_cycle();
      load = 1'b0;
      run(DIV);
      checks++;
      if (blade !== 6'b111110) begin errors++; $display("FAIL rotate_fix got blade=%b want 111110", blade); end
   endtask

   task automatic test_bounce();
      int exp_seq[11] = '{2, 4, 8, 16, 32, 16, 8, 4, 2, 1, 2};
      mode = 2'b11; load = 1'b1; load_value = 6'd1;
      clk_cycle();
      load = 1'b0;
      foreach (exp_seq[i]) begin
         run(DIV);
         checks++;
         if (blade !== ~W'(exp_seq[i])) begin
            errors++; $display("FAIL bounce_step%0d got blade=%b want %b", i, blade, ~W'(exp_seq[i]));
         end
      end
   endtask

   task automatic test_enable_collisions();
      logic led_hold;
      int   waited;
      bit   seen;
      mode = 2'b00; enable = 1'b1; load = 1'b1; load_value = 6'h07;
      clk_cycle();
      load = 1'b0;
      run(2);
      led_hold = led;
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         clk_cycle();
         checks++;
         if (blade !== 6'h38 || led !== led_hold || tick !== 1'b0) begin
            errors++;
            $display("FAIL freeze cyc%0d got blade=%h led=%b tick=%b want 38 %b 0", i, blade, led, tick, led_hold);
         end
      end
      enable = 1'b1;
      waited = 0; seen = 1'b0;
      while (!seen && waited < 12) begin
         clk_cycle();
         waited++;
         if (tick === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen || waited != DIV) begin errors++; $display("FAIL reenable_latency got %0d seen=%0b want %0d", waited, seen, DIV); end
      checks++;
      if (blade !== 6'h37) begin errors++; $display("FAIL reenable_step got blade=%h want 37", blade); end
      run(DIV - 1);
      load = 1'b1; load_value = 6'h2A;
      clk_cycle();
      load = 1'b0;
      checks++;
      if (tick !== 1'b0 || blade !== 6'h15) begin
         errors++; $display("FAIL load_beats_step got tick=%b blade=%h want 0 15", tick, blade);
      end
   endtask

   task automatic test_reset_mid();
      mode = 2'b11; enable = 1'b1; load = 1'b1; load_value = 6'd1;
      clk_cycle();
      load = 1'b0;
      run(6 * DIV);
      checks++;
      if (blade !== ~W'(16)) begin errors++; $display("FAIL mid_setup got blade=%b want %b", blade, ~W'(16)); end
      run(2);
      reset_n = 1'b0;
      clk_cycle();
      reset_n = 1'b1;
      checks++;
      if (blade !== 6'h3F || led !== 1'b0 || tick !== 1'b0) begin
         errors++; $display("FAIL mid_reset got blade=%h led=%b tick=%b want 3f 0 0", blade, led, tick);
      end
      run(DIV);
      checks++;
      if (blade !== ~W'(1)) begin errors++; $display("FAIL mid_first got blade=%b want %b", blade, ~W'(1)); end
      run(DIV);
      checks++;
      if (blade !== ~W'(2)) begin errors++; $display("FAIL mid_upward got blade=%b want %b", blade, ~W'(2)); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         reset_n    = ($urandom_range(0, 79) != 0);
         load       = ($urandom_range(0, 24) == 0);
         load_value = W'($urandom);
         enable     = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
         clk_cycle();
         checks++;
         if (blade !== ~W'(m_pat) || led !== m_led[0] || tick !== m_tick[0]) begin
            errors++;
            $display("FAIL random cyc%0d got blade=%b led=%b tick=%b want %b %b %b",
                     i, blade, led, tick, ~W'(m_pat), m_led[0], m_tick[0]);
         end
      end
      reset_n = 1'b1; load = 1'b0;
   endtask

   initial begin
      m_cnt = 0; m_pat = 0; m_dir = 0; m_tick = 0; m_led = 0;
      reset_n = 1'b0; enable = 1'b0; mode = 2'b00; load = 1'b0; load_value = '0;
      @(negedge clk);
      test_reset();
      test_upcount_wrap();
      test_rotate();
      test_bounce();
      test_enable_collisions();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
